candy_alu_issue: RTL and testbench
==================================

// Module: candy_alu_issue
// PURPOSE
// - Operand issue stage directly upstream of candy_alu: queues decoded ALU ops, drives
//   aluop/reg1/reg2 into the ALU, waits the op's latency, captures the ALU result.
// - Decouples the decode side (valid/ready) from ALU timing; EXE_MUL is multi-cycle.
// PARAMETERS
// - DATA_W   24  operand/result width (= `RegBus width)
// - OP_W      8  ALU opcode width (= `AluOpBus width)
// - DEPTH     4  queue entries; power of 2, >=2
// - ALU_LAT   1  clock edges from issue to result sample, all ops except EXE_MUL; >=1
// - MUL_LAT   3  clock edges from issue to result sample for EXE_MUL; >=1
// PORTS
// - clk          in   1            clock, rising edge
// - rst          in   1            synchronous reset, active-high (`RstEnable = 1'b1)
// - in_valid_i   in   1            upstream op valid
// - in_ready_o   out  1            queue can accept (count_o < DEPTH)
// - in_aluop_i   in   OP_W         opcode
// - in_reg1_i    in   DATA_W       operand 1
// - in_reg2_i    in   DATA_W       operand 2
// - in_fwd_i     in   2            [0]: reg1 <- last result; [1]: reg2 <- last result
//                                  (only with CANDY_ISSUE_FWD_EN)
// - aluop_o      out  OP_W         to candy_alu aluop_i
// - reg1_o       out  DATA_W       to candy_alu reg1_i
// - reg2_o       out  DATA_W       to candy_alu reg2_i
// - alu_res_i    in   DATA_W       from candy_alu res_o
// - res_o        out  DATA_W       captured result, held until next capture
// - res_valid_o  out  1            one-cycle pulse: res_o updated
// - busy_o       out  1            state == WAIT
// - count_o      out  $clog2(DEPTH)+1  queue occupancy
// BEHAVIOUR
// - Reset: all outputs 0 except in_ready_o = 1. Queue empty, state IDLE, wait counter 0.
// - Queue:
//   - Circular FIFO; rd/wr pointers wrap modulo DEPTH.
//   - Push on in_valid_i & in_ready_o. in_ready_o depends only on registered count.
//   - When full, no push, even if a pop happens in the same cycle.
//   - Push and pop in the same cycle: count unchanged.
// - FSM:
//   - IDLE: if count_o != 0, at the edge: pop head; load aluop_o/reg1_o/reg2_o;
//     wait counter <= (op == `EXE_MUL ? MUL_LAT : ALU_LAT) - 1; state <= WAIT.
//   - WAIT: if counter != 0, decrement. If counter == 0, at the edge:
//     res_o <= alu_res_i; res_valid_o <= 1.
//     Then, if the queue is non-empty, issue the next head in the same edge (stay in WAIT);
//     otherwise go to IDLE.
//   - aluop_o/reg1_o/reg2_o hold their values between issues.
// - Timing: push at edge t -> issue at t+1 -> capture at t+1+LAT -> res_valid_o high in
//   the following cycle. Throughput is one op per LAT cycles (one per cycle when LAT = 1).
// - Results are delivered in issue order. No arithmetic here; widths pass through unchanged.
// - Reset mid-WAIT: in-flight op discarded, no res_valid_o, queued entries dropped.
// CONFIGURATION
// - CANDY_ISSUE_FWD_EN defined:
//   - in_fwd_i exists and is stored per entry.
//   - At issue, each flagged operand is replaced by the forward source.
//   - Forward source = alu_res_i if a capture occurs on the same edge, else res_o.
//   - Forwarding after reset with no prior capture yields 0.
// - CANDY_ISSUE_FWD_EN undefined: in_fwd_i port absent; operands always taken from the queue.
// TESTING
// - Reset: rst=1 for 3 cycles -> all outputs 0, in_ready_o=1, count_o=0, res_valid_o never high.
// - MUL: push EXE_MUL, 24'd113, 24'd32345 at edge t -> aluop_o/reg1_o/reg2_o set at t+1;
//   res_o=24'd3654985 with res_valid_o pulse right after edge t+1+MUL_LAT.
// - Back-to-back: 4 non-MUL ops pushed on consecutive cycles, ALU_LAT=1 -> 4 consecutive
//   res_valid_o pulses, in order.
// - Full: hold in_valid_i with MUL ops -> in_ready_o=0 exactly when count_o==4;
//   every accepted op produces exactly one result, none lost or duplicated.
// - Reset mid-op: assert rst while busy_o=1 with 2 queued -> next cycle count_o=0,
//   busy_o=0, no res_valid_o afterward.
// - FWD (macro on): MUL 113,32345 then MUL fwd=2'b01, reg2=24'd2 issued at capture edge
//   -> second res_o=24'd7309970.

Source files
------------

// File: rtl/candy_alu_issue.sv
// candy_alu_issue: operand queue and issue/wait sequencer sitting in front of candy_alu.
// Optional feature macro CANDY_ISSUE_FWD_EN: per-entry forwarding of the last result into the operands.
module candy_alu_issue #(
    parameter int              DATA_W  = 24,
    parameter int              OP_W    = 8,
    parameter int              DEPTH   = 4,
    parameter int              ALU_LAT = 1,
    parameter int              MUL_LAT = 3,
    parameter logic [OP_W-1:0] EXE_MUL = OP_W'(8'hA8)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [OP_W-1:0]            in_aluop_i,
    input  logic [DATA_W-1:0]          in_reg1_i,
    input  logic [DATA_W-1:0]          in_reg2_i,
`ifdef CANDY_ISSUE_FWD_EN
    input  logic [1:0]                 in_fwd_i,
`endif
    output logic [OP_W-1:0]            aluop_o,
    output logic [DATA_W-1:0]          reg1_o,
    output logic [DATA_W-1:0]          reg2_o,
    input  logic [DATA_W-1:0]          alu_res_i,
    output logic [DATA_W-1:0]          res_o,
    output logic                       res_valid_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    // state  | meaning
    // S_IDLE | nothing in flight, issue as soon as the queue is non-empty
    // S_WAIT | op in flight, counting down to the result sample edge
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state;
    logic [LAT_W-1:0]   wait_cnt;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    logic [OP_W-1:0]    q_op   [DEPTH];
    logic [DATA_W-1:0]  q_reg1 [DEPTH];
    logic [DATA_W-1:0]  q_reg2 [DEPTH];
`ifdef CANDY_ISSUE_FWD_EN
    logic [1:0]         q_fwd  [DEPTH];
    logic [DATA_W-1:0]  fwd_src;
`endif

    logic               push;
    logic               pop;
    logic               capture;
    logic [LAT_W-1:0]   head_lat;
    logic [DATA_W-1:0]  head_reg1;
    logic [DATA_W-1:0]  head_reg2;

    assign in_ready_o = (count_o != CNT_W'(DEPTH));
    assign busy_o     = (state == S_WAIT);

    always_comb begin
        push     = in_valid_i && in_ready_o;
        capture  = (state == S_WAIT) && (wait_cnt == '0);
        pop      = (count_o != '0) && ((state == S_IDLE) || capture);
        head_lat = (q_op[rd_ptr] == EXE_MUL) ? LAT_W'(MUL_LAT - 1) : LAT_W'(ALU_LAT - 1);
`ifdef CANDY_ISSUE_FWD_EN
        // A result captured on this very edge is newer than res_o, so it wins.
        fwd_src   = capture ? alu_res_i : res_o;
        head_reg1 = q_fwd[rd_ptr][0] ? fwd_src : q_reg1[rd_ptr];
        head_reg2 = q_fwd[rd_ptr][1] ? fwd_src : q_reg2[rd_ptr];
`else
        head_reg1 = q_reg1[rd_ptr];
        head_reg2 = q_reg2[rd_ptr];
`endif
    end

    // Queue storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr]   <= in_aluop_i;
            q_reg1[wr_ptr] <= in_reg1_i;
            q_reg2[wr_ptr] <= in_reg2_i;
`ifdef CANDY_ISSUE_FWD_EN
            q_fwd[wr_ptr]  <= in_fwd_i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_o     <= '0;
            aluop_o     <= '0;
            reg1_o      <= '0;
            reg2_o      <= '0;
            res_o       <= '0;
            res_valid_o <= 1'b0;
        end else begin
            res_valid_o <= capture;
            if (capture) begin
                res_o <= alu_res_i;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                aluop_o  <= q_op[rd_ptr];
                reg1_o   <= head_reg1;
                reg2_o   <= head_reg2;
                wait_cnt <= head_lat;
                state    <= S_WAIT;
            end else if (capture) begin
                state    <= S_IDLE;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - LAT_W'(1);
            end

            case ({push, pop})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: tb/tb_candy_alu_issue.sv
// Self-checking bench for candy_alu_issue; a behavioural ALU stands in for candy_alu.
// Results are predicted per accepted op and matched against res_valid_o pulses in order.
module tb_candy_alu_issue;

    localparam logic [7:0] OP_MUL = 8'hA8;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_OR  = 8'h25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_aluop = '0;
    logic [23:0] in_reg1 = '0;
    logic [23:0] in_reg2 = '0;
    logic [1:0]  in_fwd = '0;
    logic [7:0]  aluop;
    logic [23:0] reg1, reg2, alu_res, res;
    logic        res_valid, busy;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    candy_alu_issue dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_aluop_i  (in_aluop),
        .in_reg1_i   (in_reg1),
        .in_reg2_i   (in_reg2),
`ifdef CANDY_ISSUE_FWD_EN
        .in_fwd_i    (in_fwd),
`endif
        .aluop_o     (aluop),
        .reg1_o      (reg1),
        .reg2_o      (reg2),
        .alu_res_i   (alu_res),
        .res_o       (res),
        .res_valid_o (res_valid),
        .busy_o      (busy),
        .count_o     (count)
    );

    function automatic logic [23:0] ref_alu(input logic [7:0] op, input logic [23:0] a, input logic [23:0] b);
        case (op)
            OP_MUL:  return a * b;
            OP_ADD:  return a + b;
            OP_XOR:  return a ^ b;
            default: return a | b;
        endcase
    endfunction

    always_comb alu_res = ref_alu(aluop, reg1, reg2);

    function automatic logic [7:0] rand_op(input int mul_pct);
        if (int'($urandom_range(0, 99)) < mul_pct) return OP_MUL;
        case ($urandom_range(0, 2))
            0:       return OP_ADD;
            1:       return OP_XOR;
            default: return OP_OR;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [7:0] op, input logic [23:0] a,
                         input logic [23:0] b, input logic [1:0] f);
        in_valid = v;
        in_aluop = op;
        in_reg1  = a;
        in_reg2  = b;
        in_fwd   = f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, 2'b00);
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_pulse: res_valid=%b required 0", res_valid); end
        end
        n_cmp++;
        if (count !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl: count=%0d ready=%b busy=%b required 0 1 0", count, in_ready, busy);
        end
        n_cmp++;
        if (aluop !== 8'd0 || reg1 !== 24'd0 || reg2 !== 24'd0 || res !== 24'd0) begin
            n_err++; $display("FAIL reset_data: aluop=%0h reg1=%0h reg2=%0h res=%0h required all 0", aluop, reg1, reg2, res);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0 || count !== 3'd0) begin
            n_err++; $display("FAIL reset_release: res_valid=%b count=%0d required 0 0", res_valid, count);
        end
    endtask

    task automatic test_mul();
        @(negedge clk);
        drive(1'b1, OP_MUL, 24'd113, 24'd32345, 2'b00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) drive(1'b0, '0, '0, '0, 2'b00);
            case (k)
                0: begin
                    n_cmp++;
                    if (count !== 3'd1) begin n_err++; $display("FAIL mul_push: count=%0d required 1", count); end
                end
                1: begin
                    n_cmp++;
                    if (aluop !== OP_MUL || reg1 !== 24'd113 || reg2 !== 24'd32345 || busy !== 1'b1) begin
                        n_err++; $display("FAIL mul_issue: aluop=%0h reg1=%0d reg2=%0d busy=%b required a8 113 32345 1", aluop, reg1, reg2, busy);
                    end
                end
                2, 3: begin
                    n_cmp++;
                    if (res_valid !== 1'b0) begin n_err++; $display("FAIL mul_early: res_valid=%b at k=%0d required 0", res_valid, k); end
                end
                4: begin
                    n_cmp++;
                    if (res_valid !== 1'b1 || res !== 24'd3654985) begin
                        n_err++; $display("FAIL mul_result: res_valid=%b res=%0d required 1 3654985", res_valid, res);
                    end
                end
                default: begin
                    n_cmp++;
                    if (res_valid !== 1'b0 || busy !== 1'b0) begin
                        n_err++; $display("FAIL mul_done: res_valid=%b busy=%b required 0 0", res_valid, busy);
                    end
                end
            endcase
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int first = -1;
        int last = -1;
        logic [7:0]  op;
        logic [23:0] a, b, e;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
                last = k;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra: res=%0h with nothing outstanding", res);
                end else begin
                    e = exp_q.pop_front();
                    if (res !== e) begin n_err++; $display("FAIL b2b_data: res=%0h required %0h", res, e); end
                end
            end
            if (k < 4) begin
                op = rand_op(0);
                a  = 24'($urandom);
                b  = 24'($urandom);
                drive(1'b1, op, a, b, 2'b00);
                n_cmp++;
                if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: in_ready=%b required 1", in_ready); end
                exp_q.push_back(ref_alu(op, a, b));
            end else begin
                drive(1'b0, '0, '0, '0, 2'b00);
            end
        end
        n_cmp++;
        if (pulses != 4 || first != 3 || last != 6) begin
            n_err++; $display("FAIL b2b_timing: pulses=%0d first=%0d last=%0d required 4 3 6", pulses, first, last);
        end
    endtask

    task automatic test_full();
        int accepted = 0;
        int pulses = 0;
        bit saw_full = 0;
        bit drained = 0;
        logic [7:0]  op;
        logic [23:0] a, b, e;
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                pulses++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL full_extra: res=%0h with nothing outstanding", res);
                end else begin
                    e = exp_q.pop_front();
                    if (res !== e) begin n_err++; $display("FAIL full_data: res=%0h required %0h", res, e); end
                end
            end
            n_cmp++;
            if (in_ready !== (count < 3'd4) || count > 3'd4) begin
                n_err++; $display("FAIL full_ready: in_ready=%b count=%0d", in_ready, count);
            end
            if (count == 3'd4) saw_full = 1;
            if (k < 40) begin
                op = rand_op(75);
                a  = 24'($urandom);
                b  = 24'($urandom);
                drive(1'b1, op, a, b, 2'b00);
                if (in_ready === 1'b1) begin
                    accepted++;
                    exp_q.push_back(ref_alu(op, a, b));
                end
            end else begin
                drive(1'b0, '0, '0, '0, 2'b00);
                if (exp_q.size() == 0 && busy === 1'b0 && !drained) begin
                    drained = 1;
                    k = 250;
                end
            end
        end
        n_cmp++;
        if (!drained || exp_q.size() != 0) begin
            n_err++; $display("FAIL full_drain: outstanding=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (!saw_full) begin n_err++; $display("FAIL full_reached: max occupancy never hit 4"); end
        n_cmp++;
        if (pulses != accepted) begin n_err++; $display("FAIL full_count: results=%0d required %0d", pulses, accepted); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (i >= 3 && busy === 1'b1 && count == 3'd2) begin
                found = 1;
                rst = 1'b1;
                drive(1'b0, '0, '0, '0, 2'b00);
            end else if (i < 3) begin
                drive(1'b1, OP_MUL, 24'($urandom), 24'($urandom), 2'b00);
            end else begin
                drive(1'b0, '0, '0, '0, 2'b00);
            end
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL rstmid_setup: busy=%b count=%0d never reached 1 2", busy, count); end
        @(negedge clk);
        n_cmp++;
        if (count !== 3'd0 || busy !== 1'b0 || res_valid !== 1'b0 || aluop !== 8'd0) begin
            n_err++; $display("FAIL rstmid_state: count=%0d busy=%b res_valid=%b aluop=%0h required 0 0 0 0", count, busy, res_valid, aluop);
        end
        rst = 1'b0;
        exp_q.delete();
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_pulse: res_valid=%b required 0", res_valid); end
        end
    endtask

`ifdef CANDY_ISSUE_FWD_EN
    task automatic test_fwd();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            case (k)
                0: drive(1'b1, OP_ADD, 24'd5, 24'd6, 2'b11);
                4: drive(1'b1, OP_MUL, 24'd113, 24'd32345, 2'b00);
                5: drive(1'b1, OP_MUL, 24'd7, 24'd2, 2'b01);
                default: drive(1'b0, '0, '0, '0, 2'b00);
            endcase
            case (k)
                2: begin
                    n_cmp++;
                    if (reg1 !== 24'd0 || reg2 !== 24'd0) begin n_err++; $display("FAIL fwd_zero: reg1=%0d reg2=%0d required 0 0", reg1, reg2); end
                end
                3: begin
                    n_cmp++;
                    if (res_valid !== 1'b1 || res !== 24'd0) begin n_err++; $display("FAIL fwd_zero_res: res_valid=%b res=%0d required 1 0", res_valid, res); end
                end
                9: begin
                    n_cmp++;
                    if (res_valid !== 1'b1 || res !== 24'd3654985 || reg1 !== 24'd3654985 || reg2 !== 24'd2) begin
                        n_err++; $display("FAIL fwd_issue: res=%0d reg1=%0d reg2=%0d required 3654985 3654985 2", res, reg1, reg2);
                    end
                end
                12: begin
                    n_cmp++;
                    if (res_valid !== 1'b1 || res !== 24'd7309970) begin n_err++; $display("FAIL fwd_result: res_valid=%b res=%0d required 1 7309970", res_valid, res); end
                end
                default: ;
            endcase
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_back_to_back();
        test_full();
        test_reset_mid();
`ifdef CANDY_ISSUE_FWD_EN
        test_fwd();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
